// File: rtl/apb_sram_bridge.sv
// APB3 completer bridging single APB transfers onto a 32x32 on-chip SRAM port.
//
// Converts byte addresses to word indices, inserts one wait state for the
// registered SRAM read, and reports misaligned or out-of-range accesses through
// pslverr without issuing any SRAM access.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   psel, penable     APB select / access phase
//   pwrite            1 = write, 0 = read
//   paddr, pwdata     APB byte address / write data
//   prdata            APB read data (zero outside the read-completion cycle)
//   pready, pslverr   transfer complete / error (error valid only with pready)
//   sram_en, sram_we  SRAM enable (one cycle per legal access) / write enable
//   sram_addr         SRAM word index
//   sram_din          SRAM write data
//   sram_dout         SRAM read data, valid the cycle after a read enable
module apb_sram_bridge #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PADDR_W = 12,
  parameter int unsigned SRAM_AW = 10,
  parameter int unsigned DEPTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0]  pwdata,
  output logic [DATA_W-1:0]  prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_din,
  input  logic [DATA_W-1:0]  sram_dout
);

  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [SRAM_AW:0] DepthW = (SRAM_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;

  logic [SRAM_AW-1:0]  word_idx;
  logic                misaligned;
  logic                out_of_range;

  assign word_idx     = paddr[SRAM_AW+1:2];
  assign misaligned   = |paddr[1:0];
  assign out_of_range = {1'b0, word_idx} >= DepthW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    unique case (state_q)
      StIdle: begin
        // Setup phase: capture the request; access phase follows next cycle.
        if (psel && !penable) begin
          addr_d  = word_idx;
          wdata_d = pwdata;
          write_d = pwrite;
          if (misaligned || out_of_range) begin
            state_d = StErr;
          end else if (pwrite) begin
            state_d = StWr;
          end else begin
            state_d = StRdIssue;
          end
        end
      end
      StWr:      state_d = StIdle;
      // Dropping psel here abandons the read before any pready is shown.
      StRdIssue: state_d = psel ? StRdDone : StIdle;
      StRdDone:  state_d = StIdle;
      StErr:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs depend on registered state only (plus sram_dout for read data).
  always_comb begin
    sram_en   = (state_q == StWr) || (state_q == StRdIssue);
    sram_we   = (state_q == StWr) && write_q;
    sram_addr = sram_en ? addr_q : '0;
    sram_din  = (state_q == StWr) ? wdata_q : '0;
    pready    = (state_q == StWr) || (state_q == StRdDone) || (state_q == StErr);
    pslverr   = (state_q == StErr);
    prdata    = (state_q == StRdDone) ? sram_dout : '0;
  end

endmodule

// File: tb/tb_apb_sram_bridge.sv
module tb_apb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  always #5 clk = ~clk;

  apb_sram_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Behavioural SRAM: synchronous write, one-cycle registered read.
  logic [31:0] sram_mem [32];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr[4:0]] <= sram_din;
      else         sram_dout <= sram_mem[sram_addr[4:0]];
    end
  end

  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic we; logic [9:0] addr; logic [31:0] din;} acc_t;

  rsp_t        rsp_q[$];
  acc_t        acc_q[$];
  logic [31:0] ref_mem [32];
  int          total = 0;
  int          bad = 0;
  int          en_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected SRAM accesses and APB completions as the DUT shows them.
  always @(negedge clk) begin : monitor
    acc_t a;
    rsp_t r;
    if (!rst) begin
      if (sram_en) begin
        en_count++;
        if (acc_q.size() == 0) begin
          check("unexpected sram_en", 32'(sram_en), 32'd0);
        end else begin
          a = acc_q.pop_front();
          check("sram_we", 32'(sram_we), 32'(a.we));
          check("sram_addr", 32'(sram_addr), 32'(a.addr));
          if (a.we) check("sram_din", sram_din, a.din);
        end
      end
      if (pready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected pready", 32'(pready), 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("prdata", prdata, r.rdata);
          check("pslverr", 32'(pslverr), 32'(r.err));
        end
      end else begin
        check("prdata zero while not ready", prdata, 32'd0);
      end
    end
  end

  // One APB transfer starting at posedge+1; returns at posedge+1 after completion
  // with psel low, so an immediate follow-up call gives a back-to-back setup.
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d);
    int idx = int'(a[11:2]);
    bit err = (a[1:0] != 2'b00) || (idx >= 32);
    int exp_cyc;
    int cyc;
    int en0;
    if (err) begin
      rsp_q.push_back('{rdata: 32'd0, err: 1'b1});
      exp_cyc = 2;
    end else if (wr) begin
      ref_mem[idx] = d;
      rsp_q.push_back('{rdata: 32'd0, err: 1'b0});
      acc_q.push_back('{we: 1'b1, addr: 10'(idx), din: d});
      exp_cyc = 2;
    end else begin
      rsp_q.push_back('{rdata: ref_mem[idx], err: 1'b0});
      acc_q.push_back('{we: 1'b0, addr: 10'(idx), din: 32'd0});
      exp_cyc = 3;
    end
    en0     = en_count;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge clk);
    #1 penable = 1'b1;
    cyc = 2;
    @(negedge clk);
    while (!pready && cyc < 10) begin
      @(posedge clk);
      #1 cyc++;
      @(negedge clk);
    end
    if (!pready) check("pready timeout", 32'(pready), 32'd1);
    check("completion cycles", 32'(cyc), 32'(exp_cyc));
    @(posedge clk);
    #1;
    check("sram_en pulses per transfer", 32'(en_count - en0), err ? 32'd0 : 32'd1);
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]  ix;
    logic [1:0]  lo;
    logic [31:0] v;
    int          kind;

    for (int i = 0; i < 32; i++) begin
      v           = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_dout = '0;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    rst       = 1'b1;

    #1;
    check("reset pready", 32'(pready), 32'd0);
    check("reset pslverr", 32'(pslverr), 32'd0);
    check("reset sram_en", 32'(sram_en), 32'd0);
    check("reset sram_we", 32'(sram_we), 32'd0);
    check("reset prdata", prdata, 32'd0);
    check("reset sram_addr", 32'(sram_addr), 32'd0);
    check("reset sram_din", sram_din, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Write then read, boundaries, misaligned and out-of-range.
    xfer(1'b1, 12'h010, 32'hDEADBEEF);
    idle(1);
    xfer(1'b0, 12'h010, 32'h0);
    xfer(1'b1, 12'h000, 32'hA5A5_0001);
    xfer(1'b0, 12'h000, 32'h0);
    xfer(1'b1, 12'h07C, 32'h7C7C_7C7C);
    xfer(1'b0, 12'h07C, 32'h0);
    xfer(1'b0, 12'h080, 32'h0);
    xfer(1'b1, 12'h012, 32'h5555_5555);
    xfer(1'b0, 12'h010, 32'h0);
    idle(2);

    // Back-to-back with no idle cycles.
    xfer(1'b1, 12'h008, 32'h1111_1111);
    xfer(1'b1, 12'h00C, 32'h2222_2222);
    xfer(1'b0, 12'h008, 32'h0);
    xfer(1'b0, 12'h00C, 32'h0);
    idle(2);

    // Abort: read setup, then psel drops in the wait state.
    acc_q.push_back('{we: 1'b0, addr: 10'd8, din: 32'd0});
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 12'h020;
    @(posedge clk);
    #1 psel = 1'b0;
    idle(3);
    check("abort sram access seen", 32'(acc_q.size()), 32'd0);
    xfer(1'b0, 12'h020, 32'h0);

    // Reset asserted while the read wait state is active.
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 12'h024;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid-read reset pready", 32'(pready), 32'd0);
    check("mid-read reset sram_en", 32'(sram_en), 32'd0);
    check("mid-read reset prdata", prdata, 32'd0);
    psel = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    xfer(1'b0, 12'h024, 32'h0);
    idle(1);

    // Randomised mix of legal, misaligned and out-of-range transfers.
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        ix = 10'($urandom_range(0, 31));
        lo = 2'($urandom_range(1, 3));
      end else if (kind == 1) begin
        ix = 10'($urandom_range(32, 1023));
        lo = 2'b00;
      end else begin
        ix = 10'($urandom_range(0, 31));
        lo = 2'b00;
      end
      xfer(1'($urandom_range(0, 1)), {ix, lo}, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(3);
    check("response queue drained", 32'(rsp_q.size()), 32'd0);
    check("sram access queue drained", 32'(acc_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
